// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Width of the per-bit countdown that runs from clk_div-1 to 0.
  function automatic int unsigned baud_cnt_width(input int unsigned clk_div);
    return $clog2(clk_div);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy; head word is visible on rdata while not empty.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [Width-1:0]       wdata,
  input  logic                   pop,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first frames sent back-to-back.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CntW = baud_cnt_width(CLK_DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] BaudLoad = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic                 bit_done, parity_on;

  uart_sync_fifo #(
    .Width(DATA_BITS),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (in_valid),
    .wdata(in_data),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign in_ready = ~fifo_full;
  assign busy     = (state_q != StIdle);
  assign bit_done = (baud_q == '0);

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_bit_q, par_bit_d;
  assign parity_on = par_en_q;
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ parity_odd;
  assign parity_on     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    baud_d   = bit_done ? baud_q : baud_q - 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      StIdle: fifo_pop = ~fifo_empty;
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          baud_d  = BaudLoad;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          baud_d  = BaudLoad;
          if (bit_q == LastData) begin
            bit_d   = '0;
            state_d = parity_on ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          baud_d  = BaudLoad;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (bit_done) begin
          baud_d = BaudLoad;
          if (bit_q == LastStop) begin
            bit_d    = '0;
            state_d  = StIdle;
            fifo_pop = ~fifo_empty;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop always starts a new frame, whether from idle or straight out of stop.
    if (fifo_pop) begin
      state_d = StStart;
      baud_d  = BaudLoad;
      bit_d   = '0;
      shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par_en_d  = parity_en;
      par_bit_d = (^fifo_rdata) ^ parity_odd;
`endif
    end
  end

  always_comb begin
    tx = UART_IDLE_LVL;
    unique case (state_q)
      StStart:  tx = UART_START_LVL;
      StData:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx = par_bit_q;
`endif
      default:  tx = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

endmodule
